// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM gate generator: FSM encoding, float32 field layout
// and gate decode helpers.
package pwm_pkg;

   typedef enum logic [2:0] {
      StOff  = 3'd0,
      StHi   = 3'd1,
      StDtLo = 3'd2,
      StLo   = 3'd3,
      StDtHi = 3'd4
   } pwm_state_e;

   localparam int unsigned FLOAT_W_DEF    = 32;
   localparam int unsigned DEAD_STEPS_DEF = 2;
   localparam int unsigned CNT_W          = 4;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned MANT_MSB = 22;
   localparam int unsigned MANT_LSB = 0;
   localparam logic [7:0]  EXP_MAX  = 8'hFF;

   // Returns {gate_hi, gate_lo}; only the two conducting states drive a gate.
   function automatic logic [1:0] gates_of(pwm_state_e s);
      logic [1:0] g;
      g = 2'b00;
      unique case (s)
         StHi:    g = 2'b10;
         StLo:    g = 2'b01;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

   function automatic logic is_inf_nan(logic [FLOAT_W_DEF-1:0] w);
      return w[EXP_MSB:EXP_LSB] == EXP_MAX;
   endfunction

endpackage

// File: rtl/float_cmp.sv
// Combinational float32 ordering of a against b. +0 and -0 compare equal; any
// Inf/NaN operand reports unordered with gt and lt both low.
module float_cmp
   import pwm_pkg::*;
#(
   parameter int unsigned FLOAT_W = FLOAT_W_DEF
) (
   input  logic [FLOAT_W-1:0] a,
   input  logic [FLOAT_W-1:0] b,
   output logic               gt,
   output logic               lt,
   output logic               unordered
);

   logic        sign_a;
   logic        sign_b;
   logic [30:0] mag_a;
   logic [30:0] mag_b;
   logic        both_zero;

   always_comb begin
      sign_a    = a[SIGN_BIT];
      sign_b    = b[SIGN_BIT];
      mag_a     = {a[EXP_MSB:EXP_LSB], a[MANT_MSB:MANT_LSB]};
      mag_b     = {b[EXP_MSB:EXP_LSB], b[MANT_MSB:MANT_LSB]};
      both_zero = (mag_a == '0) && (mag_b == '0);
      unordered = is_inf_nan(a) || is_inf_nan(b);
      gt        = 1'b0;
      lt        = 1'b0;
      if (!unordered && !both_zero) begin
         if (sign_a != sign_b) begin
            gt = !sign_a;
            lt = sign_a;
         end else if (!sign_a) begin
            gt = mag_a > mag_b;
            lt = mag_a < mag_b;
         end else begin
            // Both negative: larger magnitude is the smaller number.
            gt = mag_a < mag_b;
            lt = mag_a > mag_b;
         end
      end
   end

endmodule

// File: rtl/pwm_gate_gen.sv
// Three-stage PWM gate generator: register step, compare reference vs carrier, update
// gate FSM. Dead-time states and counter are built only with PWM_DEADTIME_EN defined.
module pwm_gate_gen
   import pwm_pkg::*;
#(
   parameter int unsigned DEAD_STEPS = DEAD_STEPS_DEF,
   parameter int unsigned FLOAT_W    = FLOAT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sta,
   input  logic [FLOAT_W-1:0] carrier_in,
   input  logic [FLOAT_W-1:0] ref_in,
   input  logic               enable,
   output logic               gate_hi,
   output logic               gate_lo,
   output logic               switch_state,
   output logic               done_sig
);

   logic               s1_valid_q;
   logic [FLOAT_W-1:0] s1_carrier_q;
   logic [FLOAT_W-1:0] s1_ref_q;
   logic               s1_en_q;

   logic               s2_valid_q;
   logic               s2_cmd_q;
   logic               s2_en_q;

   logic               cmp_gt;
   logic               cmp_lt;
   logic               cmp_unordered;
   logic               cmd_d;

   pwm_state_e         state_q;

   // S1: capture the step operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_carrier_q <= '0;
         s1_ref_q     <= '0;
         s1_en_q      <= 1'b0;
      end else begin
         s1_valid_q <= sta;
         if (sta) begin
            s1_carrier_q <= carrier_in;
            s1_ref_q     <= ref_in;
            s1_en_q      <= enable;
         end
      end
   end

   float_cmp #(
      .FLOAT_W (FLOAT_W)
   ) u_float_cmp (
      .a         (s1_ref_q),
      .b         (s1_carrier_q),
      .gt        (cmp_gt),
      .lt        (cmp_lt),
      .unordered (cmp_unordered)
   );

   // Equal or unordered operands leave gt/lt low, so cmd simply holds.
   always_comb begin
      cmd_d = s2_cmd_q;
      if (cmp_gt) begin
         cmd_d = 1'b1;
      end else if (cmp_lt || cmp_unordered) begin
         cmd_d = cmp_lt ? 1'b0 : s2_cmd_q;
      end
   end

   // S2: comparison result.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_cmd_q   <= 1'b0;
         s2_en_q    <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_cmd_q <= cmd_d;
            s2_en_q  <= s1_en_q;
         end
      end
   end

`ifdef PWM_DEADTIME_EN
   localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_STEPS);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = (cnt_q < DEAD_LIM) ? cnt_q + 1'b1 : cnt_q;
`endif

   // S3: gate FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StOff;
         gate_hi      <= 1'b0;
         gate_lo      <= 1'b0;
         switch_state <= 1'b0;
         done_sig     <= 1'b0;
`ifdef PWM_DEADTIME_EN
         cnt_q        <= '0;
`endif
      end else begin
         done_sig <= s2_valid_q;
         if (s2_valid_q) begin
            switch_state <= s2_cmd_q;
            if (!s2_en_q) begin
               state_q            <= StOff;
               {gate_hi, gate_lo} <= gates_of(StOff);
`ifdef PWM_DEADTIME_EN
               cnt_q              <= '0;
`endif
            end else begin
               unique case (state_q)
                  StOff: begin
                     state_q            <= s2_cmd_q ? StHi : StLo;
                     {gate_hi, gate_lo} <= gates_of(s2_cmd_q ? StHi : StLo);
                  end
`ifdef PWM_DEADTIME_EN
                  StHi: begin
                     if (!s2_cmd_q) begin
                        state_q            <= StDtLo;
                        {gate_hi, gate_lo} <= gates_of(StDtLo);
                        cnt_q              <= '0;
                     end
                  end
                  StLo: begin
                     if (s2_cmd_q) begin
                        state_q            <= StDtHi;
                        {gate_hi, gate_lo} <= gates_of(StDtHi);
                        cnt_q              <= '0;
                     end
                  end
                  StDtLo: begin
                     if (s2_cmd_q) begin
                        state_q            <= StHi;
                        {gate_hi, gate_lo} <= gates_of(StHi);
                        cnt_q              <= '0;
                     end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc >= DEAD_LIM) begin
                           state_q            <= StLo;
                           {gate_hi, gate_lo} <= gates_of(StLo);
                        end
                     end
                  end
                  StDtHi: begin
                     if (!s2_cmd_q) begin
                        state_q            <= StLo;
                        {gate_hi, gate_lo} <= gates_of(StLo);
                        cnt_q              <= '0;
                     end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc >= DEAD_LIM) begin
                           state_q            <= StHi;
                           {gate_hi, gate_lo} <= gates_of(StHi);
                        end
                     end
                  end
`else
                  StHi: begin
                     if (!s2_cmd_q) begin
                        state_q            <= StLo;
                        {gate_hi, gate_lo} <= gates_of(StLo);
                     end
                  end
                  StLo: begin
                     if (s2_cmd_q) begin
                        state_q            <= StHi;
                        {gate_hi, gate_lo} <= gates_of(StHi);
                     end
                  end
`endif
                  default: begin
                     state_q            <= StOff;
                     {gate_hi, gate_lo} <= gates_of(StOff);
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_gate_gen.sv
// Directed bench for pwm_gate_gen: a vector table of single steps plus hand-written
// back-to-back and reset sequences. Expectations adapt to PWM_DEADTIME_EN.
module tb_pwm_gate_gen;

   localparam logic [31:0] P_CAR = 32'h3B83126F;
   localparam logic [31:0] P_REF = 32'h3BC49BA6;
   localparam logic [31:0] N_CAR = 32'hBB83126F;
   localparam logic [31:0] N_REF = 32'hBBC49BA6;

`ifdef PWM_DEADTIME_EN
   localparam bit DT_BUILD = 1'b1;
`else
   localparam bit DT_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        sta;
   logic [31:0] carrier_in;
   logic [31:0] ref_in;
   logic        enable;
   logic        gate_hi;
   logic        gate_lo;
   logic        switch_state;
   logic        done_sig;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;

   always #5 clk = ~clk;

   pwm_gate_gen #(
      .DEAD_STEPS (2),
      .FLOAT_W    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sta          (sta),
      .carrier_in   (carrier_in),
      .ref_in       (ref_in),
      .enable       (enable),
      .gate_hi      (gate_hi),
      .gate_lo      (gate_lo),
      .switch_state (switch_state),
      .done_sig     (done_sig)
   );

   always @(negedge clk) if (gate_hi && gate_lo) overlap++;

   typedef struct {
      logic [31:0] car;
      logic [31:0] rf;
      logic        en;
      logic        dt_hi;
      logic        dt_lo;
      logic        nd_hi;
      logic        nd_lo;
      logic        sw;
   } vec_t;

   vec_t tbl[24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] c, input logic [31:0] r, input logic en);
      carrier_in = c;
      ref_in     = r;
      enable     = en;
      sta        = 1'b1;
      tick();
      sta        = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic       early;
      logic       exp_hi;
      logic       exp_lo;
      int         dones;
      int         mism;
      string      tag;

      // carrier, ref, en, {hi,lo} with dead time, {hi,lo} direct, switch_state
      tbl[0]  = '{P_CAR, P_REF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{N_CAR, N_REF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{N_CAR, N_REF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{N_CAR, N_REF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{P_CAR, P_REF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{N_CAR, N_REF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{P_CAR, P_REF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{P_CAR, P_REF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{P_CAR, P_REF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{N_CAR, N_REF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{P_CAR, P_REF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{32'h00000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{P_CAR, 32'h7FC00000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{32'h00000000, 32'h80000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{P_CAR, 32'h7FC00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{32'h7F800000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{32'hBF800000, 32'h3F800000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[18] = '{P_CAR, P_REF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{N_CAR, N_REF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{N_CAR, N_REF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[21] = '{32'h40000000, 32'h3FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[22] = '{32'hC0000000, 32'hC0000001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[23] = '{32'hC0000001, 32'hC0000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      rst        = 1'b1;
      sta        = 1'b0;
      enable     = 1'b0;
      carrier_in = '0;
      ref_in     = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_gate_hi", 32'(gate_hi), 32'd0);
      check("reset_gate_lo", 32'(gate_lo), 32'd0);
      check("reset_switch_state", 32'(switch_state), 32'd0);
      check("reset_done", 32'(done_sig), 32'd0);

      // Single steps: done must be low one edge after capture, high the next.
      for (int i = 0; i < 24; i++) begin
         issue(tbl[i].car, tbl[i].rf, tbl[i].en);
         tick();
         early = done_sig;
         tick();
         exp_hi = DT_BUILD ? tbl[i].dt_hi : tbl[i].nd_hi;
         exp_lo = DT_BUILD ? tbl[i].dt_lo : tbl[i].nd_lo;
         tag = $sformatf("vec%0d", i);
         check({tag, "_done_timing"}, 32'({early, done_sig}), 32'b01);
         check({tag, "_gate_hi"}, 32'(gate_hi), 32'(exp_hi));
         check({tag, "_gate_lo"}, 32'(gate_lo), 32'(exp_lo));
         check({tag, "_switch_state"}, 32'(switch_state), 32'(tbl[i].sw));
      end

      // Back-to-back: 20 steps on consecutive cycles, enable dropped from step 10.
      pulse_reset();
      dones = 0;
      mism  = 0;
      for (int m = 0; m < 25; m++) begin
         if (m < 20) begin
            carrier_in = P_CAR;
            ref_in     = P_REF;
            enable     = (m < 10);
            sta        = 1'b1;
         end else begin
            sta = 1'b0;
         end
         tick();
         if (done_sig) dones++;
         if (m >= 2 && m < 22) begin
            if (gate_hi !== ((m - 2) < 10) || gate_lo !== 1'b0) mism++;
         end
      end
      sta = 1'b0;
      check("b2b_done_count", 32'(dones), 32'd20);
      check("b2b_gate_mismatch_cycles", 32'(mism), 32'd0);

      // Reset one cycle after a step: nothing in flight may complete.
      issue(P_CAR, P_REF, 1'b1);
      tick();
      tick();
      check("pre_reset_gate_hi", 32'(gate_hi), 32'd1);
      issue(N_CAR, N_REF, 1'b1);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      dones = done_sig ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done_sig) dones++;
      end
      check("midrst_done_count", 32'(dones), 32'd0);
      check("midrst_outputs", 32'({gate_hi, gate_lo, switch_state}), 32'd0);

      // Step coinciding with reset is discarded.
      rst = 1'b1;
      issue(P_CAR, P_REF, 1'b1);
      rst   = 1'b0;
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done_sig) dones++;
      end
      check("sta_with_rst_done_count", 32'(dones), 32'd0);

      // FSM left OFF: a fresh positive step goes straight to HI.
      issue(P_CAR, P_REF, 1'b1);
      tick();
      tick();
      check("post_reset_step", 32'({done_sig, gate_hi, gate_lo, switch_state}), 32'b1101);

      check("gate_overlap_cycles", 32'(overlap), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_gate_gen.md
PWM_GATE_GEN -- requirements
Module: pwm_gate_gen

Interface
REQ-001 Parameter DEAD_STEPS, default 2, dead-time length counted in processed simulation steps (range 1..15).
REQ-002 Parameter FLOAT_W, default 32, width of the IEEE-754 single carrier and reference words.
REQ-003 clk  input  1  system clock; the single clock of the block.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 sta  input  1  one-cycle step strobe; carrier_in, ref_in and enable are valid in the same cycle.
REQ-006 carrier_in  input  32  triangle carrier, float32.
REQ-007 ref_in  input  32  modulating reference, float32.
REQ-008 enable  input  1  gating enable; 0 forces both gates off.
REQ-009 gate_hi  output  1  upper-switch gate.
REQ-010 gate_lo  output  1  lower-switch gate.
REQ-011 switch_state  output  1  ideal switching function (cmd) for the circuit solver.
REQ-012 done_sig  output  1  one-cycle pulse when the outputs reflect the current step.

Function
REQ-013 The datapath SHALL be a 3-stage pipeline with a valid bit per stage: S1 registers the inputs on sta; S2 compares; S3 updates the FSM and outputs.
REQ-014 done_sig SHALL pulse exactly 3 cycles after each sta, and sta on consecutive cycles SHALL be accepted without loss.
REQ-015 S2 SHALL set cmd=1 if ref_in>carrier_in, cmd=0 if ref_in<carrier_in, and hold the previous cmd when they are equal (+0 equals -0).
REQ-016 Comparison SHALL be sign-magnitude correct: signs differ means the positive operand is larger; both negative means the larger magnitude is smaller.
REQ-017 Any operand with exponent 0xFF (Inf/NaN) SHALL hold the previous cmd.
REQ-018 The FSM states SHALL be OFF, HI, DT_LO (moving to LO) and DT_HI (moving to HI), plus LO; gate_hi=1 only in HI, gate_lo=1 only in LO, and both gates are 0 in every other state.
REQ-019 Transitions SHALL occur only on S3-valid cycles.
REQ-020 OFF: if enable=1, go to HI when cmd=1, else go to LO.
REQ-021 HI: cmd=0 goes to DT_LO.
REQ-022 LO: cmd=1 goes to DT_HI.
REQ-023 DT_LO/DT_HI SHALL advance to LO/HI after DEAD_STEPS valid steps.
REQ-024 If cmd reverts during DT_LO, the FSM SHALL return to HI; if cmd reverts during DT_HI, it SHALL return to LO; the counter SHALL be cleared in both cases.
REQ-025 enable=0 SHALL force OFF on the next S3-valid cycle from any state, overriding all other transitions.
REQ-026 gate_hi and gate_lo SHALL never be 1 simultaneously.
REQ-027 switch_state SHALL equal the S3-registered cmd.
REQ-028 The dead-time counter SHALL be 4 bits and SHALL saturate at DEAD_STEPS, never wrapping.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL clear all pipeline valids, cmd, the counter, gate_hi, gate_lo, switch_state and done_sig to 0, and place the FSM in OFF.
REQ-030 A sta coinciding with rst SHALL be discarded, and rst mid-pipeline SHALL produce no done_sig for in-flight steps.

Configuration
REQ-031 With PWM_DEADTIME_EN defined, DT_LO/DT_HI and the counter SHALL be present as specified.
REQ-032 Without PWM_DEADTIME_EN, HI and LO SHALL switch directly on a cmd change, and DEAD_STEPS SHALL be ignored; latency SHALL be unchanged.

Structure
REQ-033 Shared package pwm_pkg SHALL hold the FSM state encoding, float field constants (sign bit 31, exponent 30:23, mantissa 22:0, EXP_MAX=8'hFF) and the DEAD_STEPS default.
REQ-034 The comparison SHALL be a combinational sub-module float_cmp (outputs gt, lt, unordered), instantiated in S2.

Verification
REQ-035 Positive compare: enable=1, carrier 0x3B83126F (0.004), ref 0x3BC49BA6 (0.006), one sta -> done_sig at +3 cycles, switch_state=1, gate_hi=1, gate_lo=0.
REQ-036 Negative compare: carrier 0xBB83126F, ref 0xBBC49BA6 -> cmd=0, FSM enters DT_LO with both gates 0 for 2 steps, then gate_lo=1.
REQ-037 Dead-time abort: cmd toggles 1->0->1 on consecutive steps -> gate_lo never asserts, FSM returns to HI, gate_hi=0 during the abort step only.
REQ-038 Equality and NaN: ref equals carrier (0x80000000 vs 0x00000000), then ref 0x7FC00000 -> cmd holds its previous value both times.
REQ-039 Enable drop and back-to-back: sta every cycle for 20 cycles with enable deasserted at step 10 -> 20 done_sig pulses, both gates 0 from step 10's S3 onward.
REQ-040 Reset mid-pipeline: rst asserted 1 cycle after sta -> no done_sig pulse, all outputs 0, FSM OFF; run the same bench without PWM_DEADTIME_EN -> direct HI<->LO switching.
